// File: rtl/morse_pkg.sv
// Shared state encoding and default timing constants for the Morse key front end.
package morse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRESS = 3'd1,
    ST_GAP   = 3'd2,
    ST_LGAP  = 3'd3,
    ST_STUCK = 3'd4
  } morse_state_e;

  localparam int MORSE_TICK_CYCLES = 5_000_000;
  localparam int MORSE_CNT_W       = 4;
  localparam int MORSE_DASH_TICKS  = 3;
  localparam int MORSE_LG_TICKS    = 3;
  localparam int MORSE_WG_TICKS    = 7;
  localparam int MORSE_STUCK_TICKS = 15;

endpackage

// File: rtl/morse_tick_gen.sv
// Free-running cycle counter that pulses tick_o on its terminal count.
// A synchronous clear restarts the count so ticks stay aligned to key edges.
module morse_tick_gen #(
  parameter int TICK_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [TW-1:0] tc_q, tc_d;

  assign tick_o = (tc_q == TW'(TICK_CYCLES - 1));

  always_comb begin
    tc_d = tc_q + TW'(1);
    if (clr_i || tick_o) tc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) tc_q <= '0;
    else       tc_q <= tc_d;
  end

endmodule

// File: rtl/morse_press_classifier.sv
// Classifies key presses into dot/dash and release gaps into letter/word gaps.
// Optional stuck-key detection is enabled by defining MORSE_STUCK_KEY_EN.
module morse_press_classifier
  import morse_pkg::*;
#(
  parameter int TICK_CYCLES = MORSE_TICK_CYCLES,
  parameter int CNT_W       = MORSE_CNT_W,
  parameter int DASH_TICKS  = MORSE_DASH_TICKS,
  parameter int LG_TICKS    = MORSE_LG_TICKS,
  parameter int WG_TICKS    = MORSE_WG_TICKS,
  parameter int STUCK_TICKS = MORSE_STUCK_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic dot,
  output logic dash,
  output logic lg,
  output logic wg,
  output logic pressed,
  output logic stuck
);

  morse_state_e     state_q, state_d;
  logic             key_q;
  logic             rise, fall, edge_clr, tick;
  logic             lg_hit, wg_hit;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_eff;
  logic             dot_q, dot_d, dash_q, dash_d, lg_q, lg_d, wg_q, wg_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign rise     = key & ~key_q;
  assign fall     = ~key & key_q;
  assign edge_clr = rise | fall;

  morse_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr_i (edge_clr),
    .tick_o(tick)
  );

  // cnt_eff includes a tick landing on the same edge, so a release at exactly N ticks counts N.
  assign cnt_eff = tick ? sat_inc(cnt_q) : cnt_q;
  assign cnt_d   = edge_clr ? '0 : cnt_eff;
  assign lg_hit  = tick && (cnt_q == CNT_W'(LG_TICKS - 1));
  assign wg_hit  = tick && (cnt_q == CNT_W'(WG_TICKS - 1));

`ifdef MORSE_STUCK_KEY_EN
  logic stuck_hit, stuck_q, stuck_d;
  assign stuck_hit = tick && (cnt_q == CNT_W'(STUCK_TICKS - 1));
  assign stuck     = stuck_q;
`else
  assign stuck = 1'b0 & (STUCK_TICKS > 0);
`endif

  always_comb begin
    state_d = state_q;
    dot_d   = 1'b0;
    dash_d  = 1'b0;
    lg_d    = 1'b0;
    wg_d    = 1'b0;
`ifdef MORSE_STUCK_KEY_EN
    stuck_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: if (rise) state_d = ST_PRESS;
      ST_PRESS: begin
        if (fall) begin
          if (cnt_eff >= CNT_W'(DASH_TICKS)) dash_d = 1'b1;
          else                               dot_d  = 1'b1;
          state_d = ST_GAP;
        end
`ifdef MORSE_STUCK_KEY_EN
        else if (stuck_hit) begin
          stuck_d = 1'b1;
          state_d = ST_STUCK;
        end
`endif
      end
      ST_GAP: begin
        if (rise) state_d = ST_PRESS;
        else if (lg_hit) begin
          lg_d    = 1'b1;
          state_d = ST_LGAP;
        end
      end
      ST_LGAP: begin
        if (rise) state_d = ST_PRESS;
        else if (wg_hit) begin
          wg_d    = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef MORSE_STUCK_KEY_EN
      ST_STUCK: if (fall) state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // key_q resets high so a key held through reset produces no rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= 1'b1;
      cnt_q   <= '0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
      lg_q    <= 1'b0;
      wg_q    <= 1'b0;
`ifdef MORSE_STUCK_KEY_EN
      stuck_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key;
      cnt_q   <= cnt_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
      lg_q    <= lg_d;
      wg_q    <= wg_d;
`ifdef MORSE_STUCK_KEY_EN
      stuck_q <= stuck_d;
`endif
    end
  end

  assign dot     = dot_q;
  assign dash    = dash_q;
  assign lg      = lg_q;
  assign wg      = wg_q;
  assign pressed = key_q;

endmodule

// File: doc/morse_press_classifier.md
# morse_press_classifier

Upstream timing stage of the Morse terminal. Takes the debounced key level, measures press and release durations in coarse ticks, and emits single-cycle `dot`, `dash`, `lg` (letter gap) and `wg` (word gap) pulses. These pulses drive the symbol shift register, symbol counter and UART write logic. It replaces the separate press/gap FSM, timer and tick counter with one self-contained block.

## Interface
- `TICK_CYCLES`, default 5_000_000: clk cycles per tick (50 ms at 100 MHz).
- `CNT_W`, default 4: width of the tick counter; saturates at 2^CNT_W-1.
- `DASH_TICKS`, default 3: press of at least this many ticks is a dash, otherwise a dot.
- `LG_TICKS`, default 3: release gap, in ticks, that ends a letter.
- `WG_TICKS`, default 7: release gap, in ticks, that ends a word. Must satisfy LG_TICKS < WG_TICKS ≤ 2^CNT_W-1.
- `STUCK_TICKS`, default 15: stuck-key threshold. Used only with MORSE_STUCK_KEY_EN.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `key` in 1: debounced key level, 1 = pressed.
- `dot` out 1: one-cycle pulse, a dot was keyed.
- `dash` out 1: one-cycle pulse, a dash was keyed.
- `lg` out 1: one-cycle pulse, letter ended.
- `wg` out 1: one-cycle pulse, word ended.
- `pressed` out 1: registered copy of `key` after edge detection.
- `stuck` out 1: one-cycle pulse, stuck key detected. Tied to 0 without MORSE_STUCK_KEY_EN.

## Operation
- Edge detection uses a registered `key_q`.
  - rise = key & ~key_q
  - fall = ~key & key_q
- Tick generator: counts 0..TICK_CYCLES-1 and pulses `tick` on the terminal count. It is cleared on every rise or fall.
- `cnt`: increments on `tick` and saturates. It is cleared together with the tick generator.
- States:
  - IDLE
    - rise → PRESS.
    - fall is ignored.
  - PRESS
    - fall → emit `dot` if cnt < DASH_TICKS, else `dash`; go to GAP.
  - GAP
    - rise → PRESS, continuing the same letter.
    - cnt reaching LG_TICKS → emit `lg`, go to LGAP.
  - LGAP
    - rise → PRESS, starting a new letter; no `wg`.
    - cnt reaching WG_TICKS → emit `wg`, go to IDLE.
  - STUCK (MORSE_STUCK_KEY_EN only)
    - fall → IDLE.
    - No dot/dash or gap events are produced from this state.
- Simultaneous events:
  - An edge in the same cycle as a threshold tick takes priority. Counters clear and no gap pulse is emitted.
  - At most one of dot/dash/lg/wg/stuck is high in any cycle.
- `wg` is emitted only after an `lg` in the same gap. A gap therefore produces `lg` at LG_TICKS and `wg` at WG_TICKS, or nothing if the key is pressed first.

## Timing
- Reset values:
  - state = IDLE, all pulses 0, cnt 0, tick counter 0.
  - `key_q` = 1 and `pressed` = 1, so a key held through reset is ignored until released.
- Latency, `key` to dot/dash:
  - `key` sampled 0 at edge k while key_q = 1.
  - dot/dash is high during cycle k+1 for exactly one cycle.
- Threshold pulses: `lg`/`wg`/`stuck` are registered on the same edge that cnt becomes the threshold value, and high for one cycle.
- Press duration boundary:
  - Measured as complete ticks since the rise.
  - A press released after exactly DASH_TICKS*TICK_CYCLES cycles is a dash.
  - A press released one cycle earlier is a dot.
- Reset mid-press or mid-gap: aborts silently with no pulse, and the block returns to IDLE.

## Configuration
- `MORSE_STUCK_KEY_EN` defined:
  - In PRESS, cnt reaching STUCK_TICKS emits `stuck` and moves to STUCK.
  - The press is discarded and no dash is emitted.
- `MORSE_STUCK_KEY_EN` undefined:
  - There is no STUCK state and `stuck` is 0.
  - Long presses saturate cnt and produce `dash` on release.

## Structure
- Package `morse_pkg` holds:
  - the state encoding (IDLE, PRESS, GAP, LGAP, STUCK);
  - default tick/threshold constants shared with the decoder top level.
- One sub-module, `morse_tick_gen`: a parameterised cycle counter with synchronous clear, emitting `tick`.

## Test plan
All scenarios use TICK_CYCLES=4 and default thresholds.

- Reset with `key`=1, then release → no pulses; state IDLE.
- Press 8 cycles (2 ticks), release → `dot` once, cycle after the fall sample; no `dash`.
- Press 12 cycles (3 ticks), release → `dash` once. A 11-cycle press → `dot`.
- Dot, then key idle → `lg` 12 cycles after the fall, `wg` 28 cycles after the fall, then silence.
- Dot, idle 16 cycles (`lg` seen), press again → no `wg`; next release gives a fresh `dot`/`dash`.
- With MORSE_STUCK_KEY_EN, hold 60 cycles → `stuck` at tick 15; release → no `dash`, no `lg`/`wg`.
  - Without the macro, the same stimulus → `dash` on release.
